// File: rtl/eve_pe_stream.sv
// eve_pe_stream: streaming evolution processing element.
// For each parent gene pair it applies crossover, weight perturbation,
// connection deletion and node insertion, handling one gene per cycle.
// An add-node event is serialised into three child genes.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clear_i             resets the hidden-node tracker to NUM_IO-1
//   cfg_we_i/cfg_data_i probability load {add, del, perturb}
//   in_valid_i/in_ready_o/in_last_i/parent1_i/parent2_i/rand_in_i
//                       parent-gene input handshake and per-gene random word
//   out_valid_o/out_ready_i/out_gene_o/out_last_o
//                       child-gene output handshake
//   hidden_node_max_o   running maximum node id
//
// Gene layout (A = ATTR_SZ): src [A-1:0], dst [2A-1:A], flags [3A-1:2A]
// (bit 2A enable, bit 2A+1 is_node), signed weight [GENE_SZ-1:3A].
module eve_pe_stream #(
  parameter int unsigned     GENE_SZ    = 64,
  parameter int unsigned     ATTR_SZ    = 8,
  parameter int unsigned     NUM_IO     = 4,
  parameter longint unsigned NEW_WEIGHT = 64'd1 << 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 cfg_we_i,
  input  logic [3*ATTR_SZ-1:0] cfg_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 in_last_i,
  input  logic [GENE_SZ-1:0]   parent1_i,
  input  logic [GENE_SZ-1:0]   parent2_i,
  input  logic [4*ATTR_SZ-1:0] rand_in_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [GENE_SZ-1:0]   out_gene_o,
  output logic                 out_last_o,
  output logic [ATTR_SZ-1:0]   hidden_node_max_o
);

  localparam int unsigned A = ATTR_SZ;
  localparam int unsigned W = GENE_SZ - 3 * ATTR_SZ;

  localparam logic [W-1:0] NewWeightW = W'(NEW_WEIGHT);
  localparam logic [W-1:0] WMax       = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] WMin       = {1'b1, {(W-1){1'b0}}};
  localparam logic [A-1:0] NumIoA     = A'(NUM_IO);
  localparam logic [A-1:0] HnmReset   = A'(NUM_IO - 1);

  localparam logic [2:0] StEmpty  = 3'd0;
  localparam logic [2:0] StSingle = 3'd1;
  localparam logic [2:0] StSplit0 = 3'd2;
  localparam logic [2:0] StSplit1 = 3'd3;
  localparam logic [2:0] StSplit2 = 3'd4;

  // Configuration
  logic [A-1:0] perturb_q, del_q, add_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perturb_q <= '0;
      del_q     <= '0;
      add_q     <= '0;
    end else if (cfg_we_i) begin
      perturb_q <= cfg_data_i[A-1:0];
      del_q     <= cfg_data_i[2*A-1:A];
      add_q     <= cfg_data_i[3*A-1:2*A];
    end
  end

  // Accept-time decisions
  logic [A-1:0] p1_src, p1_dst, p1_flags;
  logic         p1_en, p1_is_node;
  logic [W-1:0] w_sel, delta, w_sat, w_new;
  logic [W:0]   sum_wide;
  logic         perturb_hit, protect, del_hit, split_hit, accept;
  logic [A-1:0] hnm_q, hnm_d, merged_a, merged, new_id;
  logic         unused_p2;

  assign p1_src     = parent1_i[A-1:0];
  assign p1_dst     = parent1_i[2*A-1:A];
  assign p1_flags   = parent1_i[3*A-1:2*A];
  assign p1_en      = p1_flags[0];
  assign p1_is_node = p1_flags[1];
  assign unused_p2  = ^parent2_i[3*A-1:0];

  assign w_sel = rand_in_i[3*A] ? parent2_i[GENE_SZ-1:3*A] : parent1_i[GENE_SZ-1:3*A];
  assign delta = {{(W-A+1){rand_in_i[4*A-1]}}, rand_in_i[4*A-1:3*A+1]};

  // One extra bit exposes signed overflow: top two bits differ on wrap.
  assign sum_wide = {w_sel[W-1], w_sel} + {delta[W-1], delta};

  always_comb begin
    w_sat = sum_wide[W-1:0];
    if (sum_wide[W] != sum_wide[W-1]) begin
      w_sat = sum_wide[W] ? WMin : WMax;
    end
  end

  assign perturb_hit = rand_in_i[A-1:0] < perturb_q;
  assign w_new       = perturb_hit ? w_sat : w_sel;

  assign protect = (p1_is_node && (p1_src < NumIoA)) || in_last_i;
  assign del_hit = (rand_in_i[2*A-1:A] < del_q) && !protect;

  assign merged_a = (p1_src > hnm_q) ? p1_src : hnm_q;
  assign merged   = (p1_dst > merged_a) ? p1_dst : merged_a;
  assign new_id   = merged + A'(1);

  // The saturation test uses the merged max so the new id never wraps,
  // even when this gene itself carries the all-ones id.
  assign split_hit = !del_hit && !p1_is_node && p1_en &&
                     (rand_in_i[3*A-1:2*A] < add_q) && (merged != '1);

  // Node tracker
  always_comb begin
    hnm_d = hnm_q;
    if (clear_i) begin
      hnm_d = HnmReset;
    end else if (accept) begin
      hnm_d = split_hit ? new_id : merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hnm_q <= HnmReset;
    end else begin
      hnm_q <= hnm_d;
    end
  end

  assign hidden_node_max_o = hnm_q;

  // S1 register
  logic               s1_valid_q, s1_valid_d;
  logic [GENE_SZ-1:0] s1_gene_q, s1_gene_d;
  logic               s1_last_q, s1_last_d;
  logic               s1_split_q, s1_split_d;
  logic [A-1:0]       s1_new_id_q, s1_new_id_d;

  logic [2:0]         state_q, state_d;
  logic               final_beat, s1_move;

  assign final_beat = (state_q == StSingle) || (state_q == StSplit2);
  assign s1_move    = (state_q == StEmpty) || (final_beat && out_ready_i);
  assign in_ready_o = !s1_valid_q || s1_move;
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_gene_d   = s1_gene_q;
    s1_last_d   = s1_last_q;
    s1_split_d  = s1_split_q;
    s1_new_id_d = s1_new_id_q;
    if (s1_move) begin
      s1_valid_d = 1'b0;
    end
    // Deleted genes are consumed here and never reach S1.
    if (accept && !del_hit) begin
      s1_valid_d  = 1'b1;
      s1_gene_d   = {w_new, p1_flags, p1_dst, p1_src};
      s1_last_d   = in_last_i;
      s1_split_d  = split_hit;
      s1_new_id_d = new_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_gene_q   <= '0;
      s1_last_q   <= 1'b0;
      s1_split_q  <= 1'b0;
      s1_new_id_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_gene_q   <= s1_gene_d;
      s1_last_q   <= s1_last_d;
      s1_split_q  <= s1_split_d;
      s1_new_id_q <= s1_new_id_d;
    end
  end

  // Output stage
  logic [GENE_SZ-1:0] out_gene_q, out_gene_d;
  logic               out_last_q, out_last_d;
  logic [GENE_SZ-1:0] hold_gene_q, hold_gene_d;
  logic [A-1:0]       hold_new_id_q, hold_new_id_d;
  logic               hold_last_q, hold_last_d;

  logic [A-1:0]       hold_src, hold_dst, hold_flags_en;
  logic [W-1:0]       hold_w;
  logic [GENE_SZ-1:0] beat0;

  assign hold_src      = hold_gene_q[A-1:0];
  assign hold_dst      = hold_gene_q[2*A-1:A];
  assign hold_w        = hold_gene_q[GENE_SZ-1:3*A];
  // New connections are enabled, plain connections.
  assign hold_flags_en = {hold_gene_q[3*A-1:2*A+2], 1'b0, 1'b1};

  always_comb begin
    beat0        = s1_gene_q;
    beat0[2*A]   = 1'b0;
  end

  always_comb begin
    state_d       = state_q;
    out_gene_d    = out_gene_q;
    out_last_d    = out_last_q;
    hold_gene_d   = hold_gene_q;
    hold_new_id_d = hold_new_id_q;
    hold_last_d   = hold_last_q;
    case (state_q)
      StSplit0: begin
        if (out_ready_i) begin
          state_d    = StSplit1;
          out_gene_d = {NewWeightW, hold_flags_en, hold_new_id_q, hold_src};
          out_last_d = 1'b0;
        end
      end
      StSplit1: begin
        if (out_ready_i) begin
          state_d    = StSplit2;
          out_gene_d = {hold_w, hold_flags_en, hold_dst, hold_new_id_q};
          out_last_d = hold_last_q;
        end
      end
      default: begin
        // StEmpty, StSingle, StSplit2: s1_move already folds in out_ready.
        if (s1_move) begin
          if (s1_valid_q) begin
            hold_gene_d   = s1_gene_q;
            hold_new_id_d = s1_new_id_q;
            hold_last_d   = s1_last_q;
            if (s1_split_q) begin
              state_d    = StSplit0;
              out_gene_d = beat0;
              out_last_d = 1'b0;
            end else begin
              state_d    = StSingle;
              out_gene_d = s1_gene_q;
              out_last_d = s1_last_q;
            end
          end else begin
            state_d    = StEmpty;
            out_last_d = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StEmpty;
      out_gene_q    <= '0;
      out_last_q    <= 1'b0;
      hold_gene_q   <= '0;
      hold_new_id_q <= '0;
      hold_last_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_gene_q    <= out_gene_d;
      out_last_q    <= out_last_d;
      hold_gene_q   <= hold_gene_d;
      hold_new_id_q <= hold_new_id_d;
      hold_last_q   <= hold_last_d;
    end
  end

  assign out_valid_o = (state_q != StEmpty);
  assign out_gene_o  = out_gene_q;
  assign out_last_o  = out_last_q && out_valid_o;

endmodule

// File: tb/tb_eve_pe_stream.sv
// Directed bench for eve_pe_stream: passthrough, crossover/perturb with
// saturation, deletion rules, node split with backpressure, tracker
// saturation, clear and asynchronous reset mid-split.
module tb_eve_pe_stream;

  localparam logic [39:0] NewW = 40'h00_0001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        cfg_we;
  logic [23:0] cfg_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [63:0] parent1;
  logic [63:0] parent2;
  logic [31:0] rand_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_gene;
  logic        out_last;
  logic [7:0]  hnm;

  int n_cmp  = 0;
  int n_fail = 0;

  eve_pe_stream dut (
    .clk               (clk),
    .rst               (rst),
    .clear_i           (clear),
    .cfg_we_i          (cfg_we),
    .cfg_data_i        (cfg_data),
    .in_valid_i        (in_valid),
    .in_ready_o        (in_ready),
    .in_last_i         (in_last),
    .parent1_i         (parent1),
    .parent2_i         (parent2),
    .rand_in_i         (rand_in),
    .out_valid_o       (out_valid),
    .out_ready_i       (out_ready),
    .out_gene_o        (out_gene),
    .out_last_o        (out_last),
    .hidden_node_max_o (hnm)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic [39:0] w, input logic [7:0] fl,
                                     input logic [7:0] d, input logic [7:0] s);
    return {w, fl, d, s};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [23:0] d);
    cfg_we   = 1'b1;
    cfg_data = d;
    step();
    cfg_we   = 1'b0;
  endtask

  // Presents one pair for a single cycle; returns #1 after the accept edge.
  task automatic drive(input logic [63:0] p1, input logic [63:0] p2,
                       input logic [31:0] r, input logic l);
    in_valid = 1'b1;
    parent1  = p1;
    parent2  = p2;
    rand_in  = r;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  logic [63:0] pt_gene [4];

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    cfg_we    = 1'b0;
    cfg_data  = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    parent1   = '0;
    parent2   = '0;
    rand_in   = '0;
    out_ready = 1'b1;
    pt_gene[0] = mk(40'd10, 8'h01, 8'd5, 8'd0);
    pt_gene[1] = mk(40'd20, 8'h01, 8'd6, 8'd1);
    pt_gene[2] = mk(40'd30, 8'h01, 8'd5, 8'd2);
    pt_gene[3] = mk(40'd40, 8'h01, 8'd7, 8'd3);

    // Reset state
    step();
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_gene", out_gene, 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_hnm", 64'(hnm), 64'd3);
    rst = 1'b0;
    step();

    // Passthrough, back-to-back, last gene flagged
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        in_valid = 1'b1;
        parent1  = pt_gene[i];
        parent2  = '0;
        rand_in  = '0;
        in_last  = (i == 3);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      step();
      if (i == 0 || i == 5) begin
        chk("pt_idle_valid", 64'(out_valid), 64'd0);
      end else begin
        chk("pt_valid", 64'(out_valid), 64'd1);
        chk("pt_gene", out_gene, pt_gene[i-1]);
        chk("pt_last", 64'(out_last), 64'(i == 4));
      end
    end
    chk("pt_hnm", 64'(hnm), 64'd7);

    // Crossover from parent2 plus perturb by -3
    cfg(24'h0000FF);
    drive(mk(40'd100, 8'h01, 8'd5, 8'd1), mk(40'd200, 8'h01, 8'd9, 8'd9),
          32'hFB00_0000, 1'b0);
    step();
    chk("xo_gene", out_gene, mk(40'd197, 8'h01, 8'd5, 8'd1));
    chk("xo_hnm", 64'(hnm), 64'd7);

    // Positive and negative saturation
    drive(mk(40'h7F_FFFF_FFFF, 8'h01, 8'd5, 8'd1), 64'd0, 32'h0A00_0000, 1'b0);
    step();
    chk("sat_pos", out_gene, mk(40'h7F_FFFF_FFFF, 8'h01, 8'd5, 8'd1));
    drive(mk(40'h80_0000_0000, 8'h01, 8'd5, 8'd1), 64'd0, 32'hFA00_0000, 1'b0);
    step();
    chk("sat_neg", out_gene, mk(40'h80_0000_0000, 8'h01, 8'd5, 8'd1));

    // Deletion
    cfg(24'h00FF00);
    drive(mk(40'd7, 8'h01, 8'd6, 8'd2), 64'd0, 32'd0, 1'b0);
    step();
    chk("del_conn_valid", 64'(out_valid), 64'd0);
    drive(mk(40'd9, 8'h03, 8'd2, 8'd2), 64'd0, 32'd0, 1'b0);
    step();
    chk("del_io_node_kept", out_gene, mk(40'd9, 8'h03, 8'd2, 8'd2));
    drive(mk(40'd9, 8'h03, 8'd5, 8'd5), 64'd0, 32'd0, 1'b0);
    step();
    chk("del_hidden_node", 64'(out_valid), 64'd0);
    drive(mk(40'd11, 8'h01, 8'd6, 8'd3), 64'd0, 32'd0, 1'b1);
    step();
    chk("del_last_kept", out_gene, mk(40'd11, 8'h01, 8'd6, 8'd3));
    chk("del_last_flag", 64'(out_last), 64'd1);

    // Raise tracker to 9
    cfg(24'h000000);
    drive(mk(40'd1, 8'h01, 8'd9, 8'd0), 64'd0, 32'd0, 1'b0);
    step();
    chk("hnm9_gene", out_gene, mk(40'd1, 8'h01, 8'd9, 8'd0));
    chk("hnm9", 64'(hnm), 64'd9);

    // Split with a queued gene and backpressure during SPLIT1
    cfg(24'hFF0000);
    drive(mk(40'd50, 8'h01, 8'd4, 8'd1), 64'd0, 32'd0, 1'b1);
    chk("split_hnm", 64'(hnm), 64'd10);
    step();
    chk("split0_gene", out_gene, mk(40'd50, 8'h00, 8'd4, 8'd1));
    chk("split0_last", 64'(out_last), 64'd0);
    in_valid = 1'b1;
    parent1  = mk(40'd77, 8'h03, 8'd8, 8'd8);
    rand_in  = '0;
    in_last  = 1'b0;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("split1_gene", out_gene, mk(NewW, 8'h01, 8'd10, 8'd1));
    chk("split1_in_ready", 64'(in_ready), 64'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_gene", out_gene, mk(NewW, 8'h01, 8'd10, 8'd1));
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    chk("split2_gene", out_gene, mk(40'd50, 8'h01, 8'd4, 8'd10));
    chk("split2_last", 64'(out_last), 64'd1);
    chk("split2_in_ready", 64'(in_ready), 64'd1);
    step();
    chk("queued_gene", out_gene, mk(40'd77, 8'h03, 8'd8, 8'd8));
    chk("queued_last", 64'(out_last), 64'd0);
    step();
    chk("split_drain", 64'(out_valid), 64'd0);
    chk("split_hnm_end", 64'(hnm), 64'd10);

    // Tracker saturation suppresses the split
    cfg(24'h000000);
    drive(mk(40'd0, 8'h01, 8'd255, 8'd0), 64'd0, 32'd0, 1'b0);
    step();
    chk("hnm255_gene", out_gene, mk(40'd0, 8'h01, 8'd255, 8'd0));
    chk("hnm255", 64'(hnm), 64'd255);
    cfg(24'hFF0000);
    drive(mk(40'd33, 8'h01, 8'd6, 8'd2), 64'd0, 32'd0, 1'b0);
    step();
    chk("nosplit_gene", out_gene, mk(40'd33, 8'h01, 8'd6, 8'd2));
    step();
    chk("nosplit_single", 64'(out_valid), 64'd0);
    chk("nosplit_hnm", 64'(hnm), 64'd255);

    // Clear, then reset in the middle of a split
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_hnm", 64'(hnm), 64'd3);
    drive(mk(40'd50, 8'h01, 8'd5, 8'd1), 64'd0, 32'd0, 1'b0);
    chk("rs_hnm", 64'(hnm), 64'd6);
    step();
    step();
    chk("rs_split1", out_gene, mk(NewW, 8'h01, 8'd6, 8'd1));
    #1 rst = 1'b1;
    #1;
    chk("rs_out_valid", 64'(out_valid), 64'd0);
    chk("rs_out_gene", out_gene, 64'd0);
    chk("rs_hnm_reset", 64'(hnm), 64'd3);
    chk("rs_in_ready", 64'(in_ready), 64'd1);
    #1 rst = 1'b0;
    step();
    chk("rs_after", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
